// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the LCD bus arbiter.
// Optional feature macro used by the top: LCD_ARB_BEAT_CNT_EN.
package lcd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        WR_LOW  = 2'd2,
        WR_HIGH = 2'd3
    } wr_state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DMA = 1'b1
    } grant_e;

    localparam logic LCD_CMD = 1'b0;
    localparam logic LCD_DAT = 1'b1;

    localparam int CYC_W = 4;

    // Phase counters count down to zero, so a phase of N cycles loads N-1.
    function automatic logic [CYC_W-1:0] cyc_load(input int cyc);
        return CYC_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/lcd_wr_strobe.sv
// Write-strobe timing engine: SETUP, WR_LOW and WR_HIGH phases with a
// start/done handshake. lcd_wr_n comes straight from a flop.
module lcd_wr_strobe
    import lcd_arb_pkg::*;
#(
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    output logic wr_n,
    output logic busy,
    output logic done
);

    localparam logic [CYC_W-1:0] LOW_LOAD  = cyc_load(WR_LOW_CYC);
    localparam logic [CYC_W-1:0] HIGH_LOAD = cyc_load(WR_HIGH_CYC);

    wr_state_e        state_r;
    logic [CYC_W-1:0] cnt_r;
    logic             wr_n_r;
    logic             busy_r;

    // Phase sequencer; the strobe level is updated on phase entry so it never glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            wr_n_r  <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= SETUP;
                        busy_r  <= 1'b1;
                    end
                end
                SETUP: begin
                    state_r <= WR_LOW;
                    cnt_r   <= LOW_LOAD;
                    wr_n_r  <= 1'b0;
                end
                WR_LOW: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= WR_HIGH;
                        cnt_r   <= HIGH_LOAD;
                        wr_n_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                WR_HIGH: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                    wr_n_r  <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_n = wr_n_r;
    assign busy = busy_r;
    assign done = (state_r == WR_HIGH) && (cnt_r == 4'd0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Arbitrates CPU command/data beats and DMA pixel bursts onto an 8080-style LCD bus.
// Define LCD_ARB_BEAT_CNT_EN to build the completed-beat counter.
module lcd_bus_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_dc,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              dma_valid,
    output logic              dma_ready,
    input  logic              dma_last,
    input  logic [DATA_W-1:0] dma_data,
    output logic              lcd_d_c_n,
    output logic              lcd_wr_n,
    output logic [DATA_W-1:0] lcd_data,
    output logic              busy,
    output logic              dma_active,
    output logic [31:0]       beat_cnt
);

    grant_e            grant_s;
    logic              cpu_acc_s;
    logic              dma_acc_s;
    logic              busy_s;
    logic              done_s;
    logic              dma_active_r;
    logic              d_c_n_r;
    logic [DATA_W-1:0] data_r;

    // Grant: a held DMA lock excludes the CPU; otherwise the CPU has priority.
    always_comb begin
        grant_s = GNT_DMA;
        if (dma_active_r) begin
            grant_s = GNT_DMA;
        end else if (cpu_valid) begin
            grant_s = GNT_CPU;
        end else begin
            grant_s = GNT_DMA;
        end
    end

    // Ready is gated by reset so no handshake can complete while held in reset.
    assign cpu_acc_s = reset_n && !busy_s && (grant_s == GNT_CPU) && cpu_valid;
    assign dma_acc_s = reset_n && !busy_s && (grant_s == GNT_DMA) && dma_valid;

    // Capture the accepted beat and maintain the DMA burst lock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r       <= {DATA_W{1'b0}};
            d_c_n_r      <= LCD_DAT;
            dma_active_r <= 1'b0;
        end else if (cpu_acc_s) begin
            data_r  <= cpu_data;
            d_c_n_r <= cpu_dc;
        end else if (dma_acc_s) begin
            data_r       <= dma_data;
            d_c_n_r      <= LCD_DAT;
            dma_active_r <= !dma_last;
        end
    end

    lcd_wr_strobe #(
        .WR_LOW_CYC  (WR_LOW_CYC),
        .WR_HIGH_CYC (WR_HIGH_CYC)
    ) u_strobe (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (cpu_acc_s || dma_acc_s),
        .wr_n    (lcd_wr_n),
        .busy    (busy_s),
        .done    (done_s)
    );

`ifdef LCD_ARB_BEAT_CNT_EN
    logic [31:0] beat_cnt_r;

    // Count beats as they retire from WR_HIGH back to IDLE; wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt_r <= 32'd0;
        end else if (done_s) begin
            beat_cnt_r <= beat_cnt_r + 32'd1;
        end
    end

    assign beat_cnt = beat_cnt_r;
`else
    logic unused_done_s;
    assign unused_done_s = done_s;
    assign beat_cnt      = 32'd0;
`endif

    assign cpu_ready  = cpu_acc_s;
    assign dma_ready  = dma_acc_s;
    assign lcd_d_c_n  = d_c_n_r;
    assign lcd_data   = data_r;
    assign busy       = busy_s;
    assign dma_active = dma_active_r;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter: vector table plus hand-built
// sequences, with a scoreboard checking every completed LCD write strobe.
module tb_lcd_bus_arbiter;

    localparam int WL = 2;
    localparam int WH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_valid, cpu_dc, dma_valid, dma_last;
    logic [15:0] cpu_data, dma_data;
    logic        cpu_ready, dma_ready, lcd_d_c_n, lcd_wr_n, busy, dma_active;
    logic [15:0] lcd_data;
    logic [31:0] beat_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;
    int exp_beats = 0;
    logic [16:0] exp_q[$];

    typedef struct {
        logic        cv;
        logic        cdc;
        logic [15:0] cd;
        logic        dv;
        logic        dl;
        logic [15:0] dd;
        logic        exp_cr;
        logic        exp_dr;
        logic        exp_dc;
        logic [15:0] exp_data;
        logic        exp_lock;
    } vec_t;

    vec_t vecs[10];
    vec_t v_tmp;

    lcd_bus_arbiter #(
        .DATA_W      (16),
        .WR_LOW_CYC  (WL),
        .WR_HIGH_CYC (WH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .cpu_dc     (cpu_dc),
        .cpu_data   (cpu_data),
        .dma_valid  (dma_valid),
        .dma_ready  (dma_ready),
        .dma_last   (dma_last),
        .dma_data   (dma_data),
        .lcd_d_c_n  (lcd_d_c_n),
        .lcd_wr_n   (lcd_wr_n),
        .lcd_data   (lcd_data),
        .busy       (busy),
        .dma_active (dma_active),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_wr_n", 32'(lcd_wr_n), 32'd1);
        chk("rst_d_c_n", 32'(lcd_d_c_n), 32'd1);
        chk("rst_data", 32'(lcd_data), 32'd0);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst_dma_ready", 32'(dma_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dma_active", 32'(dma_active), 32'd0);
        chk("rst_beat_cnt", beat_cnt, 32'd0);
    endtask

    // Called one cycle after an accept; returns with the DUT idle again.
    task automatic wait_idle();
        repeat (WL + WH + 1) tick();
        @(negedge clk);
        chk("idle_after_beat", 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        logic acc;
        acc = v.exp_cr | v.exp_dr;
        tick();
        cpu_valid = v.cv; cpu_dc = v.cdc; cpu_data = v.cd;
        dma_valid = v.dv; dma_last = v.dl; dma_data = v.dd;
        @(negedge clk);
        chk("cpu_ready", 32'(cpu_ready), 32'(v.exp_cr));
        chk("dma_ready", 32'(dma_ready), 32'(v.exp_dr));
        if (acc) begin
            exp_q.push_back({v.exp_dc, v.exp_data});
            exp_beats++;
        end
        tick();
        cpu_valid = 1'b0;
        dma_valid = 1'b0;
        @(negedge clk);
        chk("dma_active", 32'(dma_active), 32'(v.exp_lock));
        chk("busy_setup", 32'(busy), 32'(acc));
        if (acc) begin
            chk("wr_n_setup", 32'(lcd_wr_n), 32'd1);
            for (int k = 2; k <= 2 + WL + WH; k++) begin
                tick();
                @(negedge clk);
                chk("wr_n_phase", 32'(lcd_wr_n), (k >= 2 && k < 2 + WL) ? 32'd0 : 32'd1);
                chk("busy_phase", 32'(busy), (k == 2 + WL + WH) ? 32'd0 : 32'd1);
                chk("data_hold", 32'(lcd_data), 32'(v.exp_data));
                chk("dc_hold", 32'(lcd_d_c_n), 32'(v.exp_dc));
            end
        end
    endtask

    // Scoreboard: every rising strobe edge must match the oldest expected beat.
    logic prev_wr = 1'b1;
    int   low_cnt = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_wr = 1'b1;
            low_cnt = 0;
        end else begin
            if (lcd_wr_n == 1'b0) begin
                low_cnt++;
            end else if (prev_wr == 1'b0) begin
                chk("wr_low_len", 32'(low_cnt), 32'(WL));
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL sb_unexpected: strobe with data 0x%0h, none expected", lcd_data);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    chk("sb_dc", 32'(lcd_d_c_n), 32'(e[16]));
                    chk("sb_data", 32'(lcd_data), 32'(e[15:0]));
                end
                low_cnt = 0;
            end
            prev_wr = lcd_wr_n;
        end
    end

    initial begin
        //            cv    cdc   cd        dv    dl    dd        cr    dr    dc    data      lock
        vecs[0] = '{1'b1, 1'b0, 16'h002C, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h002C, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hA5A5, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h0036, 1'b1, 1'b0, 16'h5555, 1'b1, 1'b0, 1'b0, 16'h0036, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h7777, 1'b0, 1'b1, 1'b1, 16'h7777, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 16'h0011, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 16'h0022, 1'b1, 1'b1, 16'h8888, 1'b0, 1'b1, 1'b1, 16'h8888, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};

        // Power-on reset with requests pending.
        reset_n = 1'b0;
        cpu_valid = 1'b1; cpu_dc = 1'b0; cpu_data = 16'h0000;
        dma_valid = 1'b1; dma_last = 1'b0; dma_data = 16'h0000;
        @(negedge clk); chk_reset();
        @(negedge clk); chk_reset();
        cpu_valid = 1'b0; dma_valid = 1'b0;
        tick();
        reset_n = 1'b1;

        // Reset in the middle of WR_LOW discards the beat and lifts the strobe at once.
        tick();
        cpu_valid = 1'b1; cpu_dc = 1'b1; cpu_data = 16'hBEEF;
        @(negedge clk);
        chk("d_cpu_ready", 32'(cpu_ready), 32'd1);
        tick();
        cpu_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("d_in_wr_low", 32'(lcd_wr_n), 32'd0);
        #2;
        reset_n = 1'b0;
        cpu_valid = 1'b1; dma_valid = 1'b1;
        #1;
        chk_reset();
        exp_beats = 0;
        repeat (2) begin
            @(negedge clk);
            chk_reset();
        end
        cpu_valid = 1'b0; dma_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        v_tmp = '{1'b1, 1'b0, 16'h1357, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1357, 1'b0};
        run_vec(v_tmp);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Simultaneous request: CPU first, DMA accepted exactly one beat period later.
        tick();
        cpu_valid = 1'b1; cpu_dc = 1'b0; cpu_data = 16'h002A;
        dma_valid = 1'b1; dma_last = 1'b1; dma_data = 16'hCAFE;
        @(negedge clk);
        chk("b_cpu_first", 32'(cpu_ready), 32'd1);
        chk("b_dma_wait", 32'(dma_ready), 32'd0);
        exp_q.push_back({1'b0, 16'h002A}); exp_beats++;
        for (int c = 1; c <= 2 + WL + WH; c++) begin
            tick();
            if (c == 1) cpu_valid = 1'b0;
            @(negedge clk);
            chk("b_dma_ready", 32'(dma_ready), (c == 2 + WL + WH) ? 32'd1 : 32'd0);
            chk("b_cpu_ready", 32'(cpu_ready), 32'd0);
        end
        exp_q.push_back({1'b1, 16'hCAFE}); exp_beats++;
        tick();
        dma_valid = 1'b0;
        wait_idle();

        // Four-beat DMA burst holds off a waiting CPU until the last beat.
        tick();
        dma_valid = 1'b1; dma_last = 1'b0; dma_data = 16'h1111;
        for (int c = 0; c <= 24; c++) begin
            if (c > 0) tick();
            if (c == 1) begin
                cpu_valid = 1'b1; cpu_dc = 1'b1; cpu_data = 16'h0BAD;
            end
            if (c % 6 == 1) begin
                if (c / 6 < 3) begin
                    dma_data = 16'((c / 6 + 2) * 4369);
                    dma_last = (c / 6 + 2 == 4);
                end else begin
                    dma_valid = 1'b0;
                end
            end
            @(negedge clk);
            chk("c_dma_ready", 32'(dma_ready), (c % 6 == 0 && c < 24) ? 32'd1 : 32'd0);
            chk("c_cpu_ready", 32'(cpu_ready), (c == 24) ? 32'd1 : 32'd0);
            chk("c_lock", 32'(dma_active), (c >= 1 && c <= 18) ? 32'd1 : 32'd0);
            if (c % 6 == 0 && c < 24) begin
                exp_q.push_back({1'b1, 16'((c / 6 + 1) * 4369)}); exp_beats++;
            end
            if (c == 24) begin
                exp_q.push_back({1'b1, 16'h0BAD}); exp_beats++;
            end
        end
        tick();
        cpu_valid = 1'b0;
        @(negedge clk);
        chk("c_lock_clear", 32'(dma_active), 32'd0);
        wait_idle();

`ifdef LCD_ARB_BEAT_CNT_EN
        chk("beat_cnt_total", beat_cnt, 32'(exp_beats));
        tick();
        force dut.beat_cnt_r = 32'hFFFF_FFFF;
        tick();
        release dut.beat_cnt_r;
        @(negedge clk);
        chk("beat_cnt_preload", beat_cnt, 32'hFFFF_FFFF);
        v_tmp = '{1'b1, 1'b1, 16'h00AA, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h00AA, 1'b0};
        run_vec(v_tmp);
        chk("beat_cnt_wrap", beat_cnt, 32'd0);
`else
        chk("beat_cnt_off", beat_cnt, 32'd0);
`endif

        repeat (3) tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
